// File: rtl/button_parse.sv
// button_parse: per-bit push-button conditioner.
//
// Each bit of the raw, asynchronous button bus is synchronised through two
// flops, debounced against a 2**DebWidth cycle stability window and then
// turned into a fixed-length press pulse (or passed through as a debounced
// level when EdgeOutWidth is 0).
//
// Parameters
//   Width         number of independent button bits
//   DebWidth      debounce counter width; stability window = 2**DebWidth cycles
//   EdgeOutWidth  pulse length per press in cycles; 0 = out is the debounced level
//
// Ports
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset, clears all state
//   enable  1 = debounce and pulse start logic advance, 0 = frozen
//   in      raw button levels, asynchronous, active-high
//   out     per-bit press pulse (or debounced level)
module button_parse #(
  parameter int Width        = 1,
  parameter int DebWidth     = 16,
  parameter int EdgeOutWidth = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [Width-1:0] in,
  output logic [Width-1:0] out
);

  localparam logic [DebWidth-1:0] CntMax = '1;

  for (genvar g = 0; g < Width; g++) begin : g_bit
    logic                s1;
    logic                s2;
    logic                deb;
    logic [DebWidth-1:0] cnt;

    // Stage 0: two-flop synchroniser, runs regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= in[g];
        s2 <= s1;
      end
    end

    // Stage 1: debounce. Any cycle where the synchronised input agrees with
    // the debounced state restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb <= 1'b0;
        cnt <= '0;
      end else if (enable) begin
        if (s2 == deb) begin
          cnt <= '0;
        end else if (cnt == CntMax) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DebWidth'(1);
        end
      end
    end

    if (EdgeOutWidth > 0) begin : g_pulse
      localparam int             PW    = $clog2(EdgeOutWidth + 1);
      localparam logic [PW-1:0]  PLoad = PW'(EdgeOutWidth);

      logic          deb_rise;
      logic [PW-1:0] pcnt;

      // The debounced state rises on the same edge this is true, so the
      // pulse starts together with the debounced level.
      assign deb_rise = enable && s2 && !deb && (cnt == CntMax);

      // Stage 2: pulse stretcher. A new press reloads rather than adds;
      // draining continues while enable is low.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pcnt <= '0;
        end else if (deb_rise) begin
          pcnt <= PLoad;
        end else if (pcnt != '0) begin
          pcnt <= pcnt - PW'(1);
        end
      end

      assign out[g] = (pcnt != '0);
    end else begin : g_level
      assign out[g] = deb;
    end
  end

endmodule

// File: tb/tb_button_parse.sv
module tb_button_parse;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] btn;
  logic [1:0] out_a;
  logic [1:0] out_b;

  int n_cmp;
  int n_err;

  button_parse #(.Width(2), .DebWidth(3), .EdgeOutWidth(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(btn), .out(out_a)
  );

  button_parse #(.Width(2), .DebWidth(3), .EdgeOutWidth(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(btn), .out(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a press is accepted once eight consecutive enabled
  // samples of the two-cycle-delayed input disagree with the accepted level.
  // The pulse is "high for 2 edges counted from the accepting edge".
  logic [1:0] hist1;      // input sampled one edge ago
  logic [1:0] hist2;      // input sampled two edges ago
  logic [1:0] level;      // accepted (debounced) level
  int         en_cnt;     // number of enabled edges seen
  int         last_same [2];
  int         cyc;
  int         rise_at [2];
  bit         rise_ok [2];

  task automatic model_clear();
    hist1 = 2'b00;
    hist2 = 2'b00;
    level = 2'b00;
    for (int i = 0; i < 2; i++) begin
      last_same[i] = en_cnt;
      rise_ok[i]   = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_pulse();
    logic [1:0] e;
    for (int i = 0; i < 2; i++)
      e[i] = rise_ok[i] && ((cyc - rise_at[i]) < 2);
    return e;
  endfunction

  task automatic tick(input string tag);
    logic [1:0] seen;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      seen  = hist2;
      hist2 = hist1;
      hist1 = btn;
      if (enable) begin
        en_cnt++;
        for (int i = 0; i < 2; i++) begin
          if (seen[i] == level[i]) begin
            last_same[i] = en_cnt;
          end else if (en_cnt - last_same[i] == 8) begin
            level[i]     = seen[i];
            last_same[i] = en_cnt;
            if (seen[i]) begin
              rise_at[i] = cyc;
              rise_ok[i] = 1'b1;
            end
          end
        end
      end
    end
    #1;
    chk({tag, "_pulse"}, out_a, exp_pulse());
    chk({tag, "_level"}, out_b, level);
  endtask

  task automatic hold(input string tag, input logic [1:0] v, input int n);
    btn = v;
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk({tag, "_rst_pulse"}, out_a, 2'b00);
    chk({tag, "_rst_level"}, out_b, 2'b00);
  endtask

  initial begin
    int len;
    n_cmp  = 0;
    n_err  = 0;
    cyc    = 0;
    en_cnt = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    btn    = 2'b11;
    model_clear();
    #1;
    chk("reset_idle_a", out_a, 2'b00);
    chk("reset_idle_b", out_b, 2'b00);

    // Reset held with buttons pressed: nothing comes out.
    for (int k = 0; k < 4; k++) tick("in_reset");
    #3;
    rst_n = 1'b1;
    // Pulse on both bits after edges 10 and 11 counted from release.
    for (int k = 1; k <= 12; k++) begin
      tick("release");
      chk("release_direct", out_a, (k == 10 || k == 11) ? 2'b11 : 2'b00);
    end
    hold("drop_all", 2'b00, 14);
    chk("drop_all_level", out_b, 2'b00);

    // Single press on bit 0.
    btn = 2'b01;
    for (int k = 1; k <= 14; k++) begin
      tick("press0");
      chk("press0_direct", out_a, (k == 10 || k == 11) ? 2'b01 : 2'b00);
    end
    hold("unpress0", 2'b00, 14);

    // Glitch of 7 cycles is rejected, 8 cycles accepted.
    hold("glitch7", 2'b01, 7);
    hold("glitch7_low", 2'b00, 12);
    btn = 2'b01;
    for (int k = 1; k <= 8; k++) tick("press8");
    btn = 2'b00;
    for (int k = 9; k <= 14; k++) begin
      tick("press8_low");
      chk("press8_direct", out_a, (k == 10 || k == 11) ? 2'b01 : 2'b00);
    end
    hold("press8_settle", 2'b00, 6);

    // Frozen debounce: no pulse while disabled, pulse 8 enabled edges later.
    enable = 1'b0;
    hold("frozen", 2'b01, 20);
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick("thaw");
      chk("thaw_direct", out_a, (k == 8 || k == 9) ? 2'b01 : 2'b00);
    end
    hold("thaw_low", 2'b00, 14);

    // Level output on bit 1 of the EdgeOutWidth=0 instance.
    btn = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      tick("level_hi");
      chk("level_hi_direct", out_b, (k >= 10) ? 2'b10 : 2'b00);
    end
    btn = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick("level_lo");
      chk("level_lo_direct", out_b, (k < 10) ? 2'b10 : 2'b00);
    end

    // Reset during an active pulse: output drops at once, nothing resumes.
    btn = 2'b01;
    for (int k = 1; k <= 10; k++) tick("pre_rst");
    chk("pre_rst_active", out_a, 2'b01);
    btn = 2'b00;
    async_reset("midpulse");
    tick("midpulse_held");
    tick("midpulse_held");
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick("post_rst");
      chk("post_rst_direct", out_a, 2'b00);
    end

    // Randomised segments with occasional disables and resets.
    for (int s = 0; s < 60; s++) begin
      enable = ($urandom_range(0, 7) != 0);
      len    = $urandom_range(1, 14);
      hold("rand", 2'($urandom_range(0, 3)), len);
      if ($urandom_range(0, 19) == 0) begin
        async_reset("rand");
        tick("rand_held");
        #3;
        rst_n = 1'b1;
      end
    end
    enable = 1'b1;
    hold("final", 2'b00, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
